// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake, payload, control and sideband bundle.
// slave = stage side, master = upstream/downstream driver side.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 64,
   parameter int SIDE_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              flush;
   logic              bubble;
   logic [SIDE_W-1:0] side_in;
   logic [SIDE_W-1:0] side_out;
   logic [1:0]        occupancy;

   modport slave (
      input  in_valid, in_data, out_ready,
      input  flush, bubble, side_in,
      output in_ready, out_valid, out_data,
      output side_out, occupancy
   );

   modport master (
      output in_valid, in_data, out_ready,
      output flush, bubble, side_in,
      input  in_ready, out_valid, out_data,
      input  side_out, occupancy
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register, optional 2-entry skid,
// flush, bubble, free-running sideband. Ports: clk, cpurst_n, io (slave).
module pipe_stage_reg #(
   parameter int DATA_W       = 64,
   parameter int SIDE_W       = 32,
   parameter bit SKID         = 1'b1,
   parameter bit ZERO_INVALID = 1'b1
) (
   input  logic            clk,
   input  logic            cpurst_n,
   pipe_stage_reg_if.slave io
);

   logic              vld_q, vld_d;
   logic              skv_q, skv_d;
   logic              rdy_q;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [DATA_W-1:0] skd_q, skd_d;
   logic [SIDE_W-1:0] side_q;
   logic              acc, otx;

   // rdy_q is 0 in reset; with a skid it also carries !skid_full,
   // so in_ready never sees out_ready combinationally.
   assign io.in_ready = rdy_q & ~io.bubble
                      & (SKID | ~vld_q | io.out_ready);

   assign acc = io.in_valid & io.in_ready & ~io.flush;
   assign otx = vld_q & io.out_ready;

   always_comb begin
      vld_d = vld_q;
      skv_d = skv_q;
      dat_d = dat_q;
      skd_d = skd_q;
      priority case (1'b1)
         io.flush: begin
            vld_d = 1'b0;
            skv_d = 1'b0;
            if (ZERO_INVALID) dat_d = '0;
         end
         skv_q: begin
            // full: no input possible, only a drain refill
            if (otx) begin
               dat_d = skd_q;
               skv_d = 1'b0;
            end
         end
         acc: begin
            if (!vld_q || io.out_ready) begin
               dat_d = io.in_data;
               vld_d = 1'b1;
            end else begin
               skd_d = io.in_data;
               skv_d = 1'b1;
            end
         end
         otx: begin
            vld_d = 1'b0;
            if (ZERO_INVALID) dat_d = '0;
         end
         default: ;
      endcase
      if (!SKID) skv_d = 1'b0;
   end

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         vld_q  <= 1'b0;
         skv_q  <= 1'b0;
         rdy_q  <= 1'b0;
         dat_q  <= '0;
         skd_q  <= '0;
         side_q <= '0;
      end else begin
         vld_q  <= vld_d;
         skv_q  <= skv_d;
         rdy_q  <= SKID ? ~skv_d : 1'b1;
         dat_q  <= dat_d;
         skd_q  <= skd_d;
         side_q <= io.side_in;
      end
   end

   assign io.out_valid = vld_q;
   assign io.out_data  = dat_q;
   assign io.side_out  = side_q;
   // skid full implies main full
   assign io.occupancy = {skv_q, vld_q & ~skv_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives a SKID=1 and a SKID=0 stage in lockstep
// and checks both against queue-based reference models.
module tb_pipe_stage_reg;

   localparam int DW = 64;
   localparam int SW = 32;

   logic clk = 1'b0;
   logic cpurst_n = 1'b0;
   always #5 clk = ~clk;

   logic          iv, ordy, fl, bb;
   logic [DW-1:0] din;
   logic [SW-1:0] sin;

   pipe_stage_reg_if #(.DATA_W(DW), .SIDE_W(SW)) b1 ();
   pipe_stage_reg_if #(.DATA_W(DW), .SIDE_W(SW)) b0 ();

   assign b1.in_valid  = iv;
   assign b1.in_data   = din;
   assign b1.out_ready = ordy;
   assign b1.flush     = fl;
   assign b1.bubble    = bb;
   assign b1.side_in   = sin;
   assign b0.in_valid  = iv;
   assign b0.in_data   = din;
   assign b0.out_ready = ordy;
   assign b0.flush     = fl;
   assign b0.bubble    = bb;
   assign b0.side_in   = sin;

   pipe_stage_reg #(
      .DATA_W(DW), .SIDE_W(SW),
      .SKID(1'b1), .ZERO_INVALID(1'b1)
   ) u1 (
      .clk(clk), .cpurst_n(cpurst_n), .io(b1)
   );

   pipe_stage_reg #(
      .DATA_W(DW), .SIDE_W(SW),
      .SKID(1'b0), .ZERO_INVALID(1'b1)
   ) u0 (
      .clk(clk), .cpurst_n(cpurst_n), .io(b0)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] q1[$];
   logic [DW-1:0] q0[$];
   logic          alive;
   logic [SW-1:0] side_prev;
   int            max0;

   task automatic chk(string tag, logic [DW-1:0] obs,
                      logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] head(int k);
      if (k == 1) return (q1.size() > 0) ? q1[0] : '0;
      return (q0.size() > 0) ? q0[0] : '0;
   endfunction

   task automatic chk_all();
      logic r1, r0;
      r1 = alive && q1.size() < 2 && !bb;
      r0 = alive && (q0.size() == 0 || ordy) && !bb;
      chk("rdy1", DW'(b1.in_ready), DW'(r1));
      chk("vld1", DW'(b1.out_valid), DW'(q1.size() > 0));
      chk("dat1", b1.out_data, head(1));
      chk("occ1", DW'(b1.occupancy), DW'(q1.size()));
      chk("side1", DW'(b1.side_out), DW'(side_prev));
      chk("rdy0", DW'(b0.in_ready), DW'(r0));
      chk("vld0", DW'(b0.out_valid), DW'(q0.size() > 0));
      chk("dat0", b0.out_data, head(0));
      chk("occ0", DW'(b0.occupancy), DW'(q0.size()));
      chk("side0", DW'(b0.side_out), DW'(side_prev));
   endtask

   task automatic chk_rst();
      chk("rst_rdy1", DW'(b1.in_ready), '0);
      chk("rst_vld1", DW'(b1.out_valid), '0);
      chk("rst_dat1", b1.out_data, '0);
      chk("rst_occ1", DW'(b1.occupancy), '0);
      chk("rst_side1", DW'(b1.side_out), '0);
      chk("rst_rdy0", DW'(b0.in_ready), '0);
      chk("rst_vld0", DW'(b0.out_valid), '0);
      chk("rst_occ0", DW'(b0.occupancy), '0);
      chk("rst_side0", DW'(b0.side_out), '0);
   endtask

   // one cycle: drive at negedge, check, then apply model at posedge
   task automatic cyc(logic v, logic [DW-1:0] d, logic r,
                      logic f, logic b);
      logic a1, a0, o1, o0;
      iv = v; din = d; ordy = r; fl = f; bb = b;
      sin = $urandom;
      #1;
      chk_all();
      a1 = v && alive && q1.size() < 2 && !b && !f;
      a0 = v && alive && (q0.size() == 0 || r) && !b && !f;
      o1 = r && q1.size() > 0;
      o0 = r && q0.size() > 0;
      @(posedge clk);
      if (f) begin
         q1.delete();
         q0.delete();
      end else begin
         if (o1) void'(q1.pop_front());
         if (o0) void'(q0.pop_front());
         if (a1) q1.push_back(d);
         if (a0) q0.push_back(d);
      end
      if (q0.size() > max0) max0 = q0.size();
      side_prev = sin;
      @(negedge clk);
   endtask

   // assert reset between edges, check immediately, release before edge
   task automatic mid_reset();
      #2 cpurst_n = 1'b0;
      #1;
      chk_rst();
      q1.delete();
      q0.delete();
      alive = 1'b0;
      side_prev = '0;
      #1 cpurst_n = 1'b1;
      @(posedge clk);
      alive = 1'b1;
      side_prev = sin;
      @(negedge clk);
   endtask

   initial begin
      iv = 0; din = '0; ordy = 0; fl = 0; bb = 0;
      sin = 32'h1234_5678;
      alive = 1'b0;
      side_prev = '0;
      max0 = 0;
      #2;
      chk_rst();
      @(posedge clk);
      #1;
      chk_rst();
      @(negedge clk);
      mid_reset();

      // streaming
      for (int i = 1; i <= 4; i++) cyc(1, DW'(i), 1, 0, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);

      // backpressure
      cyc(1, 64'hA, 0, 0, 0);
      cyc(1, 64'hB, 0, 0, 0);
      cyc(0, '0, 0, 0, 0);
      cyc(0, '0, 0, 0, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);

      // flush with full skid, 0xC offered during flush
      cyc(1, 64'hA, 0, 0, 0);
      cyc(1, 64'hB, 0, 0, 0);
      cyc(1, 64'hC, 0, 1, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);

      // bubble over a held beat
      cyc(1, 64'h5, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 64'h6, 1, 0, 1);
      cyc(0, '0, 1, 0, 0);

      // async reset with occupancy 2
      cyc(1, 64'h8, 0, 0, 0);
      cyc(1, 64'h9, 0, 0, 0);
      mid_reset();
      cyc(1, 64'h7, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);

      // out_ready toggling with continuous input
      cyc(1, 64'h11, 1, 0, 0);
      cyc(1, 64'h12, 0, 0, 0);
      cyc(1, 64'h13, 1, 0, 0);
      cyc(1, 64'h14, 0, 0, 0);
      cyc(1, 64'h15, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) != 0,
             {$urandom, $urandom},
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) == 0);
      end
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0);

      chk("max_occ0", DW'(max0 <= 1), DW'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
